alu_ctrl_seq: RTL

Sequenced ALU control unit for the multi-cycle execute stage. It decodes ALUOp/funct into the 4-bit ALU control code, as the single-cycle decoder does. It also owns the timing of multi-cycle operations (mul, divu) through a valid/ready handshake, a latency counter, and stall/flush support. It sits between the main Decoder and the ALU/multiplier datapath.

---
 rtl/alu_ctrl_pkg.sv | 37 +++
 rtl/alu_ctrl_dec.sv | 53 +++++
 rtl/alu_ctrl_seq.sv | 96 +++++++++
 3 files changed

// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: shared ALUOp, funct and ALU control encodings plus the sequencer state type.
package alu_ctrl_pkg;
   localparam logic [2:0] ALUOP_ADD   = 3'd0;
   localparam logic [2:0] ALUOP_SUB   = 3'd1;
   localparam logic [2:0] ALUOP_RTYPE = 3'd2;
   localparam logic [2:0] ALUOP_SLT   = 3'd3;
   localparam logic [2:0] ALUOP_MEM   = 3'd4;
   localparam logic [2:0] ALUOP_OR    = 3'd5;
   localparam logic [2:0] ALUOP_LUI   = 3'd6;
   localparam logic [2:0] ALUOP_BNE   = 3'd7;

   localparam logic [5:0] FUNCT_SRA  = 6'd3;
   localparam logic [5:0] FUNCT_SRAV = 6'd7;
   localparam logic [5:0] FUNCT_JR   = 6'd8;
   localparam logic [5:0] FUNCT_MUL  = 6'd24;
   localparam logic [5:0] FUNCT_DIVU = 6'd27;
   localparam logic [5:0] FUNCT_ADDU = 6'd33;
   localparam logic [5:0] FUNCT_SUBU = 6'd35;
   localparam logic [5:0] FUNCT_AND  = 6'd36;
   localparam logic [5:0] FUNCT_OR   = 6'd37;
   localparam logic [5:0] FUNCT_SLT  = 6'd42;

   localparam logic [3:0] ALU_AND  = 4'b0000;
   localparam logic [3:0] ALU_OR   = 4'b0001;
   localparam logic [3:0] ALU_ADD  = 4'b0010;
   localparam logic [3:0] ALU_LUI  = 4'b0011;
   localparam logic [3:0] ALU_SUB  = 4'b0110;
   localparam logic [3:0] ALU_SLT  = 4'b0111;
   localparam logic [3:0] ALU_SRA  = 4'b1000;
   localparam logic [3:0] ALU_BNE  = 4'b1001;
   localparam logic [3:0] ALU_SRAV = 4'b1011;
   localparam logic [3:0] ALU_JR   = 4'b1101;
   localparam logic [3:0] ALU_DIVU = 4'b1110;
   localparam logic [3:0] ALU_MUL  = 4'b1111;

   typedef enum logic {IDLE, BUSY} state_t;
endpackage

// File: rtl/alu_ctrl_dec.sv
// alu_ctrl_dec: combinational ALUOp/funct decode into control code, multi-cycle class and illegal flag.
module alu_ctrl_dec
   import alu_ctrl_pkg::*;
#(
   parameter int FUNCT_W = 6,
   parameter int ALUOP_W = 3,
   parameter int CTRL_W  = 4
) (
   input  logic [ALUOP_W-1:0] ALUOp_i,
   input  logic [FUNCT_W-1:0] funct_i,
   output logic [CTRL_W-1:0]  ctrl_o,
   output logic               is_multi_o,
   output logic               lat_sel_o,
   output logic               illegal_o
);
   always_comb begin
      ctrl_o     = CTRL_W'(ALU_ADD);
      is_multi_o = 1'b0;
      lat_sel_o  = 1'b0;
      illegal_o  = 1'b0;
      case (ALUOp_i)
         ALUOP_W'(ALUOP_ADD),
         ALUOP_W'(ALUOP_MEM): ctrl_o = CTRL_W'(ALU_ADD);
         ALUOP_W'(ALUOP_SUB): ctrl_o = CTRL_W'(ALU_SUB);
         ALUOP_W'(ALUOP_SLT): ctrl_o = CTRL_W'(ALU_SLT);
         ALUOP_W'(ALUOP_OR):  ctrl_o = CTRL_W'(ALU_OR);
         ALUOP_W'(ALUOP_LUI): ctrl_o = CTRL_W'(ALU_LUI);
         ALUOP_W'(ALUOP_BNE): ctrl_o = CTRL_W'(ALU_BNE);
         ALUOP_W'(ALUOP_RTYPE):
            case (funct_i)
               FUNCT_W'(FUNCT_ADDU): ctrl_o = CTRL_W'(ALU_ADD);
               FUNCT_W'(FUNCT_SUBU): ctrl_o = CTRL_W'(ALU_SUB);
               FUNCT_W'(FUNCT_AND):  ctrl_o = CTRL_W'(ALU_AND);
               FUNCT_W'(FUNCT_OR):   ctrl_o = CTRL_W'(ALU_OR);
               FUNCT_W'(FUNCT_SLT):  ctrl_o = CTRL_W'(ALU_SLT);
               FUNCT_W'(FUNCT_SRA):  ctrl_o = CTRL_W'(ALU_SRA);
               FUNCT_W'(FUNCT_SRAV): ctrl_o = CTRL_W'(ALU_SRAV);
               FUNCT_W'(FUNCT_JR):   ctrl_o = CTRL_W'(ALU_JR);
               FUNCT_W'(FUNCT_MUL): begin
                  ctrl_o     = CTRL_W'(ALU_MUL);
                  is_multi_o = 1'b1;
               end
               FUNCT_W'(FUNCT_DIVU): begin
                  ctrl_o     = CTRL_W'(ALU_DIVU);
                  is_multi_o = 1'b1;
                  lat_sel_o  = 1'b1;
               end
               default: illegal_o = 1'b1;
            endcase
         default: illegal_o = 1'b1;
      endcase
   end
endmodule

// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: registered ALU control decode with valid/ready sequencing of multi-cycle mul/divu,
// latency countdown, stall and flush.
module alu_ctrl_seq
   import alu_ctrl_pkg::*;
#(
   parameter int FUNCT_W = 6,
   parameter int ALUOP_W = 3,
   parameter int CTRL_W  = 4,
   parameter int MUL_LAT = 4,
   parameter int DIV_LAT = 8
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               valid_i,
   output logic               ready_o,
   input  logic [ALUOP_W-1:0] ALUOp_i,
   input  logic [FUNCT_W-1:0] funct_i,
   input  logic               flush_i,
   output logic [CTRL_W-1:0]  ALUCtrl_o,
   output logic               valid_o,
   output logic               busy_o,
   output logic               stall_o,
   output logic               illegal_o
);
   localparam int CNT_W = $clog2(MUL_LAT > DIV_LAT ? MUL_LAT : DIV_LAT) + 1;

   state_t            state, state_n;
   logic [CNT_W-1:0]  cnt, cnt_n, cnt_dec, lat;
   logic [CTRL_W-1:0] ctrl_n, dec_ctrl;
   logic              valid_n, busy_n, stall_n, ill_n;
   logic              dec_multi, dec_lat_sel, dec_ill, accept;

   alu_ctrl_dec #(.FUNCT_W(FUNCT_W), .ALUOP_W(ALUOP_W), .CTRL_W(CTRL_W)) u_dec (
      .ALUOp_i    (ALUOp_i),
      .funct_i    (funct_i),
      .ctrl_o     (dec_ctrl),
      .is_multi_o (dec_multi),
      .lat_sel_o  (dec_lat_sel),
      .illegal_o  (dec_ill)
   );

   assign ready_o = state == IDLE;
   assign accept  = valid_i && ready_o && !flush_i;
   assign lat     = dec_lat_sel ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);
   assign cnt_dec = cnt - CNT_W'(1);

   // cnt holds the remaining BUSY cycles after the current one; 0 marks the result cycle
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      ctrl_n  = ALUCtrl_o;
      valid_n = 1'b0;
      busy_n  = 1'b0;
      stall_n = 1'b0;
      ill_n   = 1'b0;
      if (state == BUSY) begin
         if (!flush_i && cnt != '0) begin
            cnt_n   = cnt_dec;
            busy_n  = 1'b1;
            stall_n = cnt_dec != '0;
            valid_n = cnt_dec == '0;
         end else begin
            state_n = IDLE;
            cnt_n   = '0;
         end
      end else if (accept) begin
         ctrl_n  = dec_ctrl;
         ill_n   = dec_ill;
         busy_n  = dec_multi;
         cnt_n   = dec_multi ? lat : '0;
         stall_n = dec_multi && lat != '0;
         valid_n = !stall_n;
         state_n = stall_n ? BUSY : IDLE;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state     <= IDLE;
         cnt       <= '0;
         ALUCtrl_o <= CTRL_W'(ALU_ADD);
         valid_o   <= 1'b0;
         busy_o    <= 1'b0;
         stall_o   <= 1'b0;
         illegal_o <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         ALUCtrl_o <= ctrl_n;
         valid_o   <= valid_n;
         busy_o    <= busy_n;
         stall_o   <= stall_n;
         illegal_o <= ill_n;
      end
   end
endmodule
